// File: rtl/seq_arith_unit_pkg.sv
// seq_arith_unit_pkg: shared operation and FSM state encodings for the sequential arithmetic unit
//   op_e    : ADD=0, SUB=1, MUL=2, DIV=3
//   state_e : IDLE (accepting), CALC (iterating), DONE (result presented)
package arith_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/seq_arith_unit_if.sv
// seq_arith_unit_if: operation request / result handshake bundle
//   request : in_valid, in_ready, op[1:0], a, b
//   response: out_valid, out_ready, result[2*WIDTH-1:0], div_zero
//   master  : producer of operations and consumer of results
//   slave   : the arithmetic unit
interface seq_arith_unit_if #(parameter int WIDTH = 4);
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 div_zero;
   modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, div_zero);
   modport slave  (input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, div_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, WIDTH cycles busy after start
//   clk, rst            : clock, asynchronous active-high reset
//   start               : load dividend/divisor (divisor must be nonzero)
//   dividend, divisor   : unsigned operands
//   busy                : iterating
//   quotient, remainder : valid once busy falls, held until the next start
module seq_divider #(parameter int WIDTH = 4) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   shifted, diff;
   logic             ge;
   // quotient doubles as the dividend shift register: its MSB feeds the partial remainder
   assign shifted = {remainder, quotient[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};
   assign ge      = !diff[WIDTH];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         cnt       <= '0;
         dvs       <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         cnt       <= '0;
         dvs       <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (busy) begin
         remainder <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         quotient  <= {quotient[WIDTH-2:0], ge};
         cnt       <= cnt + 1'b1;
         busy      <= cnt != CW'(WIDTH - 1);
      end
   end
endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: sequential ADD/SUB/MUL/DIV unit with valid/ready handshake
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_arith_unit_if slave (in_valid/in_ready/op/a/b, out_valid/out_ready/result/div_zero)
//   ADD/SUB and DIV-by-zero complete in one cycle; MUL (inline shift-add) and DIV (seq_divider) take WIDTH+1
module seq_arith_unit import arith_pkg::*; #(
   parameter int WIDTH        = 4,
   parameter bit DEBUG_ASSERT = 1
) (
   input logic            clk,
   input logic            rst,
   seq_arith_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e             state;
   op_e                op_q, op_in;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mcand, acc, acc_n, res_q;
   logic [WIDTH-1:0]   mplier, quo, rem;
   logic [WIDTH:0]     sum, diff;
   logic               in_ready_q, out_valid_q, dz_q, div_sel, div_busy;
   logic               accept, div_start, b_zero, fast;
   assign op_in     = op_e'(bus.op);
   assign accept    = bus.in_valid && in_ready_q;
   assign b_zero    = bus.b == '0;
   assign div_start = accept && op_in == OP_DIV && !b_zero;
   assign fast      = op_in == OP_ADD || op_in == OP_SUB || (op_in == OP_DIV && b_zero);
   assign sum       = {1'b0, bus.a} + {1'b0, bus.b};
   // bit WIDTH of the widened difference is the borrow
   assign diff      = {1'b0, bus.a} - {1'b0, bus.b};
   assign acc_n     = mplier[0] ? acc + mcand : acc;
   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (bus.a),
      .divisor   (bus.b),
      .busy      (div_busy),
      .quotient  (quo),
      .remainder (rem)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= OP_ADD;
         cnt         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         res_q       <= '0;
         div_sel     <= 1'b0;
         dz_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               op_q        <= op_in;
               cnt         <= '0;
               mcand       <= {{WIDTH{1'b0}}, bus.a};
               mplier      <= bus.b;
               acc         <= '0;
               div_sel     <= div_start;
               dz_q        <= op_in == OP_DIV && b_zero;
               res_q       <= op_in == OP_ADD ? {{(WIDTH-1){1'b0}}, sum} :
                              op_in == OP_SUB ? {{(WIDTH-1){1'b0}}, diff} :
                              op_in == OP_DIV && b_zero ? {bus.a, {WIDTH{1'b1}}} : '0;
               in_ready_q  <= 1'b0;
               out_valid_q <= fast;
               state       <= fast ? DONE : CALC;
            end
            CALC: begin
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               acc    <= acc_n;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  if (op_q == OP_MUL) res_q <= acc_n;
               end
            end
            DONE: if (bus.out_ready) begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.div_zero  = dz_q;
   // divider holds its outputs after finishing, so a completed DIV reads straight from it
   assign bus.result    = (div_sel && !div_busy) ? {rem, quo} : res_q;
   if (DEBUG_ASSERT) begin : g_xchk
      always @(posedge clk)
         if (!rst && accept)
            assert (!$isunknown({bus.a, bus.b, bus.op}))
            else $warning("seq_arith_unit: X/Z on a, b or op at acceptance");
   end
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed self-checking bench for seq_arith_unit at WIDTH=4
module tb_seq_arith_unit;
   import arith_pkg::*;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   seq_arith_unit_if #(.WIDTH(W)) bus ();
   seq_arith_unit #(.WIDTH(W), .DEBUG_ASSERT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", bus.in_ready, 1);
      bus.op = op;
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask
   task automatic wait_out(output int n);
      n = 1;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask
   task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] exp_res, input logic exp_dz, input int exp_lat);
      int n;
      issue(op, a, b);
      wait_out(n);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_res"}, bus.result, exp_res);
      check({tag, "_dz"}, bus.div_zero, exp_dz);
      check({tag, "_busy"}, bus.in_ready, 0);
      @(posedge clk);
      #1;
      check({tag, "_ov_clr"}, bus.out_valid, 0);
      check({tag, "_rdy_back"}, bus.in_ready, 1);
   endtask
   initial begin
      int n, seen;
      bus.in_valid = 1'b0;
      bus.op = 2'd0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b1;
      #12;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_div_zero", bus.div_zero, 0);
      @(negedge clk) rst = 1'b0;
      run("add_15_1", OP_ADD, 4'd15, 4'd1, 8'h10, 1'b0, 1);
      run("sub_3_5", OP_SUB, 4'd3, 4'd5, 8'h1E, 1'b0, 1);
      run("sub_9_4", OP_SUB, 4'd9, 4'd4, 8'h05, 1'b0, 1);
      run("mul_15_15", OP_MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 5);
      run("mul_6_7", OP_MUL, 4'd6, 4'd7, 8'h2A, 1'b0, 5);
      run("div_13_4", OP_DIV, 4'd13, 4'd4, 8'h13, 1'b0, 5);
      run("div_9_0", OP_DIV, 4'd9, 4'd0, 8'h9F, 1'b1, 1);
      run("add_0_0", OP_ADD, 4'd0, 4'd0, 8'h00, 1'b0, 1);
      run("div_15_1", OP_DIV, 4'd15, 4'd1, 8'h0F, 1'b0, 5);
      run("div_2_7", OP_DIV, 4'd2, 4'd7, 8'h20, 1'b0, 5);
      bus.out_ready = 1'b0;
      issue(OP_MUL, 4'd12, 4'd11);
      wait_out(n);
      check("bp_lat", n, 5);
      check("bp_res", bus.result, 8'h84);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.op = OP_ADD;
         bus.a = 4'(i);
         bus.b = 4'd1;
         @(posedge clk);
         #1;
         check("bp_hold_res", bus.result, 8'h84);
         check("bp_hold_ov", bus.out_valid, 1);
         check("bp_hold_rdy", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_ov", bus.out_valid, 0);
      check("bp_release_rdy", bus.in_ready, 1);
      run("add_after_bp", OP_ADD, 4'd1, 4'd2, 8'h03, 1'b0, 1);
      issue(OP_DIV, 4'd13, 4'd4);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_ov", bus.out_valid, 0);
      check("abort_rdy", bus.in_ready, 1);
      check("abort_res", bus.result, 0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check("abort_no_result", seen, 0);
      run("add_2_3", OP_ADD, 4'd2, 4'd3, 8'h05, 1'b0, 1);
      issue(OP_ADD, 4'bxxxx, 4'd1);
      wait_out(n);
      check("xop_lat", n, 1);
      @(posedge clk);
      #1;
      check("xop_rdy_back", bus.in_ready, 1);
      run("add_after_x", OP_ADD, 4'd7, 4'd8, 8'h0F, 1'b0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width (legal range 2..32).
REQ-002 SHALL have parameter DEBUG_ASSERT, default 1, enabling X-check assertions.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operands and op valid.
REQ-006 SHALL have port in_ready, output, 1, unit accepts a new operation.
REQ-007 SHALL have port op, input, 2, operation select: ADD=0, SUB=1, MUL=2, DIV=3.
REQ-008 SHALL have port a, input, WIDTH, first operand (unsigned).
REQ-009 SHALL have port b, input, WIDTH, second operand (unsigned).
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port result, output, 2*WIDTH, packed result per REQ-018..021.
REQ-013 SHALL have port div_zero, output, 1, set with a DIV result when b==0.

Function
REQ-014 SHALL accept an operation only on a cycle where in_valid && in_ready; a, b and op are captured then.
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-016 SHALL transition IDLE->DONE on accepting ADD/SUB, IDLE->CALC on accepting MUL/DIV with b!=0, and IDLE->DONE on accepting DIV with b==0.
REQ-017 SHALL stay in CALC for exactly WIDTH cycles, one iteration per cycle, then go to DONE; latency from acceptance to out_valid is 1 cycle (ADD/SUB/DIV-by-zero) or WIDTH+1 cycles (MUL/DIV).
REQ-018 ADD: result[WIDTH:0]=a+b including carry, upper bits 0.
REQ-019 SUB: result[WIDTH-1:0]=(a-b) mod 2^WIDTH, result[WIDTH]=borrow (a<b), upper bits 0.
REQ-020 MUL: result = full 2*WIDTH-bit product via iterative shift-add.
REQ-021 DIV: result = {remainder, quotient}, each WIDTH bits, via restoring division; b==0 gives quotient all ones, remainder=a, div_zero=1.
REQ-022 SHALL assert out_valid only in DONE; result and div_zero SHALL stay stable while out_valid && !out_ready.
REQ-023 SHALL go DONE->IDLE on out_valid && out_ready; in_ready rises the following cycle (no same-cycle accept/complete overlap).
REQ-024 div_zero SHALL be 0 for every op other than DIV.
REQ-025 in_valid while busy SHALL be ignored; inputs SHALL have no effect outside acceptance.
REQ-026 With DEBUG_ASSERT=1, SHALL issue a warning-severity immediate assertion if ^{a,b,op} is X/Z at acceptance; function SHALL be unaffected.

Reset
REQ-027 rst SHALL, asynchronously, force state IDLE, in_ready=1 after release, out_valid=0, result=0, div_zero=0, and clear iteration counter and datapath registers.
REQ-028 rst asserted mid-CALC or in DONE SHALL abort the operation; no result is ever presented for it.

Structure
REQ-029 Shared package arith_pkg SHALL hold the op enum (op_e) and FSM state enum (state_e).
REQ-030 The iterative divider SHALL be a sub-module seq_divider (start, WIDTH-cycle busy, quotient/remainder out); multiplier stays inline.
REQ-031 Iteration counter SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH=4)
REQ-032 ADD a=15,b=1 -> 1 cycle later out_valid, result=8'h10; SUB a=3,b=5 -> result=8'h1E (low 4'hE, borrow 1).
REQ-033 MUL a=15,b=15 -> out_valid exactly 5 cycles after accept, result=8'hE1.
REQ-034 DIV a=13,b=4 -> 5 cycles, result={4'd1,4'd3}, div_zero=0; DIV a=9,b=0 -> 1 cycle, result={4'd9,4'hF}, div_zero=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles after MUL result -> result stable, in_ready=0, in_valid pulses ignored.
REQ-036 rst pulse 2 cycles into a DIV -> out_valid never rises for it; next ADD 2+3 -> result=8'h05.
REQ-037 Drive a=4'bxxxx at acceptance -> exactly one assertion warning, FSM still completes.
